// File: rtl/dmem_ctrl.sv
// dmem_ctrl: XLEN-wide local data RAM with byte/half/word/doubleword load/store unit.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake; accept on valid && ready
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_type            [1:0] size (b/h/w/d), [2] zero-extend load
//   req_wdata           right-aligned store data
//   rsp_valid           one-cycle response pulse, one cycle after accept
//   rsp_rdata           extended load data (0 for stores and faults)
//   rsp_fault           out-of-range, illegal size or misaligned access
//
// Optional feature (macro DMEM_MISALIGN_SPLIT_EN): misaligned accesses are
// executed instead of faulting; accesses crossing a word boundary take two
// beats through the SPLIT state.
module dmem_ctrl #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault
);
    localparam int unsigned     WBYTES    = XLEN / 8;
    localparam int unsigned     OFF_W     = $clog2(WBYTES);
    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam int unsigned     NLO_W     = OFF_W + 1;
    localparam longint unsigned MEM_BYTES = longint'(DEPTH) * WBYTES;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            state;
    logic [XLEN-1:0]   mem [DEPTH];

    logic [1:0]        size;
    logic              zext;
    int unsigned       off_i;
    int unsigned       nbytes;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              size_bad;
    logic              fault;
    logic              accept;
    logic [XLEN-1:0]   lo_data;
    logic [IDX_W-1:0]  wr_idx;
    logic [XLEN-1:0]   wr_data;
    logic [WBYTES-1:0] wr_be;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic              cross;
    logic [IDX_W-1:0]  hi_idx_q;
    logic [NLO_W-1:0]  nlo_q;
    logic [NLO_W-1:0]  nhi_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   lo_q;
`else
    logic              misal;
`endif

    // Sign- or zero-extend the low (8 << sz) bits of d to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                               input logic [1:0] sz,
                                               input logic zx);
        logic [XLEN-1:0] r;
        int unsigned     bits;
        logic            sgn;
        bits = 32'd8 << sz;
        sgn  = d[bits-1] & ~zx;
        for (int unsigned i = 0; i < XLEN; i++)
            r[i] = (i < bits) ? d[i] : sgn;
        return r;
    endfunction

    assign req_ready = !rst && (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        size     = req_type[1:0];
        zext     = req_type[2];
        off_i    = 32'(req_addr[OFF_W-1:0]);
        nbytes   = 32'd1 << size;
        idx      = req_addr[OFF_W +: IDX_W];
        in_range = 64'(req_addr) < MEM_BYTES;
        size_bad = (XLEN == 32) && (size == 2'b11);
        // Addressed bytes moved down to lane 0; for a crossing access only
        // the low-word part survives, the rest is filled from the next word.
        lo_data  = mem[idx] >> (off_i * 8);
`ifdef DMEM_MISALIGN_SPLIT_EN
        cross    = (off_i + nbytes) > WBYTES;
        fault    = !in_range || size_bad || (cross && (idx == IDX_W'(DEPTH - 1)));
`else
        misal    = (off_i & (nbytes - 1)) != 0;
        fault    = !in_range || size_bad || misal;
`endif

        wr_idx  = idx;
        wr_data = '0;
        wr_be   = '0;
        if (accept && req_we && !fault) begin
            wr_data = req_wdata << (off_i * 8);
            for (int unsigned b = 0; b < WBYTES; b++)
                wr_be[b] = (b >= off_i) && (b < off_i + nbytes);
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        // Second beat: remaining store bytes land at the bottom of word W+1.
        if (!rst && (state == SPLIT) && we_q) begin
            wr_idx  = hi_idx_q;
            wr_data = wdata_q >> (32'(nlo_q) * 8);
            for (int unsigned b = 0; b < WBYTES; b++)
                wr_be[b] = b < 32'(nhi_q);
        end
`endif
    end

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < WBYTES; b++)
            if (wr_be[b])
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fault) begin
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                        end
`ifdef DMEM_MISALIGN_SPLIT_EN
                        else if (cross) begin
                            state    <= SPLIT;
                            hi_idx_q <= idx + IDX_W'(1);
                            nlo_q    <= NLO_W'(WBYTES - off_i);
                            nhi_q    <= NLO_W'(off_i + nbytes - WBYTES);
                            size_q   <= size;
                            zext_q   <= zext;
                            we_q     <= req_we;
                            wdata_q  <= req_wdata;
                            lo_q     <= lo_data;
                        end
`endif
                        else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= req_we ? '0 : extend(lo_data, size, zext);
                        end
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                SPLIT: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= we_q ? '0 :
                        extend(lo_q | (mem[hi_idx_q] << (32'(nlo_q) * 8)), size_q, zext_q);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
